// File: rtl/ccg_pkg.sv
// Shared types and opcode map for the CCG control-code generator stages.
package ccg_pkg;

  typedef struct packed {
    logic wr;
    logic xrn;
    logic xr0;
    logic ern;
    logic isp;
    logic efl;
  } ctrl_t;

  localparam logic [7:0] OP_LSP      = 8'h10;
  localparam logic [7:0] OP_CUD      = 8'h05;
  localparam logic [7:0] OP_CUA      = 8'h06;
  localparam logic [7:0] OP_CC_BASE  = 8'h30;
  localparam logic [7:0] OP_PSH_BASE = 8'h68;
  localparam logic [7:0] OP_OUT_BASE = 8'hF8;
  localparam logic [7:0] OP_JCD_BASE = 8'h08;
  localparam logic [7:0] OP_JCA_BASE = 8'h28;
  localparam logic [7:0] OP_RTC_BASE = 8'h48;
  localparam logic [7:0] OP_JCA_LAST = 8'h3F;

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  // Opcode groups are aligned blocks of 8 or 16 codes
  function automatic logic in_block8(input logic [7:0] op, input logic [7:0] base);
    return op[7:3] == base[7:3];
  endfunction

  function automatic logic in_block16(input logic [7:0] op, input logic [7:0] base);
    return op[7:4] == base[7:4];
  endfunction

endpackage

// File: rtl/ccg4_decode.sv
// Combinational opcode decode shared by stage 4 and later stages; first match wins.
module ccg4_decode
  import ccg_pkg::*;
(
  input  logic [7:0] opcode,
  output logic       lsp,
  output logic       dsp_d,
  output logic       lop,
  output logic       efl_d
);

  always_comb begin
    lsp   = 1'b0;
    dsp_d = 1'b0;
    lop   = 1'b0;
    efl_d = 1'b0;
    if (opcode == OP_LSP) begin
      lsp = 1'b1;
    end else if ((opcode == OP_CUD) || (opcode == OP_CUA) ||
                 in_block16(opcode, OP_CC_BASE) || in_block8(opcode, OP_PSH_BASE)) begin
      dsp_d = 1'b1;
    end else if (in_block8(opcode, OP_OUT_BASE)) begin
      lop = 1'b1;
    end else if (in_block8(opcode, OP_JCD_BASE) ||
                 ((opcode >= OP_JCA_BASE) && (opcode <= OP_JCA_LAST)) ||
                 in_block8(opcode, OP_RTC_BASE)) begin
      efl_d = 1'b1;
    end
  end

endmodule

// File: rtl/ccg4_stage.sv
// Stage-4 control code generator: registers CCG3 controls, resolves condition squash,
// sequences multi-byte stack writes and counts squashed instructions.
module ccg4_stage
  import ccg_pkg::*;
#(
  parameter  int OPC_W      = 8,
  parameter  int PUSH_BYTES = 1,
  parameter  int CNT_W      = 16,
  localparam int BIDX_W     = (PUSH_BYTES > 1) ? $clog2(PUSH_BYTES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              fl,
  input  logic              wr_in,
  input  logic              xrn_in,
  input  logic              xr0_in,
  input  logic              ern_in,
  input  logic              isp_in,
  input  logic              efl_in,
  output logic              busy,
  output logic              out_valid,
  output logic              WR,
  output logic              LRN,
  output logic              LR0,
  output logic              LSP,
  output logic              DSP,
  output logic              LOP,
  output logic              ERN,
  output logic [BIDX_W-1:0] byte_idx,
  output logic [CNT_W-1:0]  sq_cnt
);

  localparam logic MULTI = (PUSH_BYTES > 1);

  logic             valid_q;
  logic [OPC_W-1:0] op_q;
  logic             fl_q;
  ctrl_t            ctrl_q;
  state_t           state;
  logic [BIDX_W-1:0] bidx_q;
  logic [CNT_W-1:0] cnt_q;

  logic lsp_d, dsp_d, lop_d, efl_d;
  logic cf, wr_r, dsp_r, in_burst, fire, start, beat, last_beat, capture;
  logic unused_bits;

  ccg4_decode u_decode (
    .opcode (op_q[7:0]),
    .lsp    (lsp_d),
    .dsp_d  (dsp_d),
    .lop    (lop_d),
    .efl_d  (efl_d)
  );

  // The flag-enable decision comes from the opcode decode, so efl and any wide opcode bits are spare.
  assign unused_bits = ctrl_q.efl ^ (^op_q);

  assign cf        = efl_d & ~fl_q;
  assign wr_r      = ctrl_q.wr & ~cf;
  assign dsp_r     = (ctrl_q.isp & cf) | (dsp_d & ~cf);
  assign in_burst  = (state == ST_BURST);
  assign fire      = valid_q & ~stall & ~flush & ~in_burst;
  assign start     = fire & wr_r & dsp_r & MULTI;
  assign beat      = in_burst & ~stall;
  assign last_beat = beat & (bidx_q == BIDX_W'(PUSH_BYTES - 1));
  assign busy      = start | (in_burst & ~last_beat);
  assign capture   = ~stall & ~busy;

  // Beat 0 is issued by the instruction's own fire cycle; BURST only covers the remaining beats.
  assign WR        = (wr_r & fire) | beat;
  assign DSP       = (dsp_r & fire) | beat;
  assign LRN       = ctrl_q.xrn & fire;
  assign LR0       = ctrl_q.xr0 & fire;
  assign ERN       = ctrl_q.ern & fire;
  assign LSP       = lsp_d & fire;
  assign LOP       = lop_d & fire;
  assign out_valid = valid_q;
  assign byte_idx  = bidx_q;
  assign sq_cnt    = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      fl_q    <= 1'b0;
      ctrl_q  <= '0;
      state   <= ST_IDLE;
      bidx_q  <= '0;
      cnt_q   <= '0;
    end else begin
      if (!in_burst && flush) begin
        valid_q <= 1'b0;
      end else if (capture) begin
        valid_q <= in_valid;
        op_q    <= opcode;
        fl_q    <= fl;
        ctrl_q  <= ctrl_t'({wr_in, xrn_in, xr0_in, ern_in, isp_in, efl_in});
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_BURST;
            bidx_q <= BIDX_W'(1);
          end
        end
        ST_BURST: begin
          if (last_beat) begin
            state  <= ST_IDLE;
            bidx_q <= '0;
          end else if (beat) begin
            bidx_q <= bidx_q + BIDX_W'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          bidx_q <= '0;
        end
      endcase

      if (fire && cf && !(&cnt_q)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ccg4_stage.sv
// Self-checking bench for ccg4_stage with 4-byte pushes and a 2-bit squash counter.
module tb_ccg4_stage;

  localparam int PB = 4;
  localparam int CW = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall = 1'b0, flush = 1'b0, in_valid = 1'b0, fl = 1'b0;
  logic       wr_in = 1'b0, xrn_in = 1'b0, xr0_in = 1'b0, ern_in = 1'b0, isp_in = 1'b0, efl_in = 1'b0;
  logic [7:0] opcode = 8'h00;
  logic       busy, out_valid, WR, LRN, LR0, LSP, DSP, LOP, ERN;
  logic [1:0] byte_idx;
  logic [CW-1:0] sq_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ccg4_stage #(.OPC_W(8), .PUSH_BYTES(PB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .opcode(opcode), .fl(fl), .wr_in(wr_in), .xrn_in(xrn_in), .xr0_in(xr0_in),
    .ern_in(ern_in), .isp_in(isp_in), .efl_in(efl_in), .busy(busy),
    .out_valid(out_valid), .WR(WR), .LRN(LRN), .LR0(LR0), .LSP(LSP), .DSP(DSP),
    .LOP(LOP), .ERN(ERN), .byte_idx(byte_idx), .sq_cnt(sq_cnt)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  // ctrl packs {wr, xrn, xr0, ern, isp, efl}
  task automatic applyStimulus(input logic v, input logic [7:0] op, input logic f,
                               input logic [5:0] ctrl, input logic s, input logic fsh);
    in_valid = v;
    opcode   = op;
    fl       = f;
    {wr_in, xrn_in, xr0_in, ern_in, isp_in, efl_in} = ctrl;
    stall    = s;
    flush    = fsh;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    applyStimulus(1'b0, 8'h00, 1'b0, 6'b0, 1'b0, 1'b0);
  endtask

  function automatic int m_dsp(input logic [7:0] op);
    return int'((op == 8'h05) || (op == 8'h06) || (op >= 8'h30 && op <= 8'h3F) ||
                (op >= 8'h68 && op <= 8'h6F));
  endfunction

  function automatic int m_efl(input logic [7:0] op);
    return int'(((op >= 8'h08 && op <= 8'h0F) || (op >= 8'h28 && op <= 8'h3F) ||
                 (op >= 8'h48 && op <= 8'h4F)) && (m_dsp(op) == 0));
  endfunction

  // Model of the instruction held in the stage plus how many push beats have gone out
  int         m_hv, m_hfl, m_beats, m_cnt;
  logic [7:0] m_hop;
  logic [5:0] m_c;
  int         cf, e_wr_r, e_dsp_r, e_fire, e_busy, e_wr, e_dsp, e_idx;

  task automatic m_capture();
    m_hv  = int'(in_valid);
    m_hop = opcode;
    m_hfl = int'(fl);
    m_c   = {wr_in, xrn_in, xr0_in, ern_in, isp_in, efl_in};
  endtask

  always @(negedge clk) begin
    if (rst) begin
      m_hv = 0; m_hop = 8'h00; m_hfl = 0; m_c = 6'b0; m_beats = 0; m_cnt = 0;
      checkOutput("m_rst_busy", int'(busy), 0);
      checkOutput("m_rst_out_valid", int'(out_valid), 0);
      checkOutput("m_rst_WR", int'(WR), 0);
      checkOutput("m_rst_byte_idx", int'(byte_idx), 0);
      checkOutput("m_rst_sq_cnt", int'(sq_cnt), 0);
    end else begin
      cf      = int'((m_efl(m_hop) != 0) && (m_hfl == 0));
      e_wr_r  = int'(m_c[5] && (cf == 0));
      e_dsp_r = int'((m_c[1] && (cf != 0)) || ((m_dsp(m_hop) != 0) && (cf == 0)));
      if (m_beats > 0) begin
        e_fire = 0;
        e_wr   = int'(!stall);
        e_dsp  = int'(!stall);
        e_idx  = m_beats;
        e_busy = int'(!(!stall && m_beats == PB - 1));
      end else begin
        e_fire = int'((m_hv != 0) && !stall && !flush);
        e_wr   = e_fire & e_wr_r;
        e_dsp  = e_fire & e_dsp_r;
        e_idx  = 0;
        e_busy = int'((e_fire != 0) && (e_wr_r != 0) && (e_dsp_r != 0) && (PB > 1));
      end
      checkOutput("m_busy", int'(busy), e_busy);
      checkOutput("m_out_valid", int'(out_valid), m_hv);
      checkOutput("m_WR", int'(WR), e_wr);
      checkOutput("m_DSP", int'(DSP), e_dsp);
      checkOutput("m_LRN", int'(LRN), e_fire & int'(m_c[4]));
      checkOutput("m_LR0", int'(LR0), e_fire & int'(m_c[3]));
      checkOutput("m_ERN", int'(ERN), e_fire & int'(m_c[2]));
      checkOutput("m_LSP", int'(LSP), e_fire & int'(m_hop == 8'h10));
      checkOutput("m_LOP", int'(LOP), e_fire & int'(m_hop >= 8'hF8));
      checkOutput("m_byte_idx", int'(byte_idx), e_idx);
      checkOutput("m_sq_cnt", int'(sq_cnt), m_cnt);

      if (e_fire != 0 && cf != 0 && m_cnt < (1 << CW) - 1) m_cnt++;
      if (m_beats > 0) begin
        if (!stall) begin
          m_beats++;
          if (m_beats == PB) begin
            m_beats = 0;
            m_capture();
          end
        end
      end else if (flush) begin
        m_hv = 0;
      end else if (e_busy != 0) begin
        m_beats = 1;
      end else if (!stall) begin
        m_capture();
      end
    end
  end

  logic [7:0] ops [18] = '{8'h05, 8'h06, 8'h30, 8'h3F, 8'h68, 8'h6F, 8'hF8, 8'hFF, 8'h08,
                           8'h0F, 8'h28, 8'h2F, 8'h48, 8'h4F, 8'h10, 8'h00, 8'h40, 8'h67};

  initial begin
    @(posedge clk); #1;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_byte_idx", int'(byte_idx), 0);
    checkOutput("reset_sq_cnt", int'(sq_cnt), 0);
    checkOutput("reset_WR", int'(WR), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // PSH burst with a stall and a flush in the middle
    applyStimulus(1'b1, 8'h6A, 1'b0, 6'b100100, 1'b0, 1'b0); tick();
    nop();
    checkOutput("psh_b0_busy", int'(busy), 1);
    checkOutput("psh_b0_WR", int'(WR), 1);
    checkOutput("psh_b0_DSP", int'(DSP), 1);
    checkOutput("psh_b0_ERN", int'(ERN), 1);
    checkOutput("psh_b0_idx", int'(byte_idx), 0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 6'b0, 1'b1, 1'b0);
    checkOutput("psh_stall_WR", int'(WR), 0);
    checkOutput("psh_stall_idx", int'(byte_idx), 1);
    checkOutput("psh_stall_busy", int'(busy), 1);
    tick();
    nop();
    checkOutput("psh_b1_WR", int'(WR), 1);
    checkOutput("psh_b1_idx", int'(byte_idx), 1);
    checkOutput("psh_b1_ERN", int'(ERN), 0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 6'b0, 1'b0, 1'b1);
    checkOutput("psh_flush_WR", int'(WR), 1);
    checkOutput("psh_flush_idx", int'(byte_idx), 2);
    tick();
    nop();
    checkOutput("psh_b3_WR", int'(WR), 1);
    checkOutput("psh_b3_idx", int'(byte_idx), 3);
    checkOutput("psh_b3_busy", int'(busy), 0);
    tick();
    checkOutput("psh_done_WR", int'(WR), 0);
    checkOutput("psh_done_out_valid", int'(out_valid), 0);

    // JCD with failed then passing condition
    applyStimulus(1'b1, 8'h09, 1'b0, 6'b100001, 1'b0, 1'b0); tick();
    nop();
    checkOutput("jcd_fail_WR", int'(WR), 0);
    checkOutput("jcd_fail_DSP", int'(DSP), 0);
    tick();
    checkOutput("jcd_fail_sq_cnt", int'(sq_cnt), 1);
    applyStimulus(1'b1, 8'h09, 1'b1, 6'b100001, 1'b0, 1'b0); tick();
    nop();
    checkOutput("jcd_pass_WR", int'(WR), 1);
    checkOutput("jcd_pass_DSP", int'(DSP), 0);
    tick();
    checkOutput("jcd_pass_sq_cnt", int'(sq_cnt), 1);

    // RTC pops only when the condition fails
    applyStimulus(1'b1, 8'h4A, 1'b0, 6'b000010, 1'b0, 1'b0); tick();
    nop();
    checkOutput("rtc_fail_DSP", int'(DSP), 1);
    tick();
    applyStimulus(1'b1, 8'h4A, 1'b1, 6'b000010, 1'b0, 1'b0); tick();
    nop();
    checkOutput("rtc_pass_DSP", int'(DSP), 0);
    tick();

    // OUT held under stall fires once on release
    applyStimulus(1'b1, 8'hFC, 1'b0, 6'b0, 1'b0, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 6'b0, 1'b1, 1'b0);
      checkOutput("out_stall_LOP", int'(LOP), 0);
      checkOutput("out_stall_valid", int'(out_valid), 1);
      tick();
    end
    nop();
    checkOutput("out_release_LOP", int'(LOP), 1);
    tick();
    checkOutput("out_after_LOP", int'(LOP), 0);

    // Flush in IDLE with LSP held; a same-cycle new instruction is dropped
    applyStimulus(1'b1, 8'h10, 1'b0, 6'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 8'hF8, 1'b0, 6'b0, 1'b0, 1'b1);
    checkOutput("flush_LSP", int'(LSP), 0);
    tick();
    nop();
    checkOutput("flush_out_valid", int'(out_valid), 0);
    checkOutput("flush_dropped_LOP", int'(LOP), 0);
    tick();

    // Two more squashed instructions saturate the 2-bit counter at 3
    applyStimulus(1'b1, 8'h09, 1'b0, 6'b100001, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 8'h2B, 1'b0, 6'b100001, 1'b0, 1'b0); tick();
    nop(); tick();
    checkOutput("sat_sq_cnt", int'(sq_cnt), 3);

    // Decode sweep, checked cycle by cycle against the model
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b1, ops[i], i[0], 6'(i * 13 + 5), (i % 5) == 3, 1'b0);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      nop(); tick();
    end

    // Reset on beat 1 of a 4-beat burst aborts it at once
    applyStimulus(1'b1, 8'h6A, 1'b0, 6'b100000, 1'b0, 1'b0); tick();
    nop(); tick();
    nop();
    checkOutput("abort_pre_idx", int'(byte_idx), 1);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_WR", int'(WR), 0);
    checkOutput("abort_idx", int'(byte_idx), 0);
    checkOutput("abort_sq_cnt", int'(sq_cnt), 0);
    tick();
    rst = 1'b0;
    nop(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccg4_stage.md
# ccg4_stage

Parametrised stage-4 control code generator for the pipelined RISC core. It registers the stage-3 control bits and the opcode, decodes the stack, output and flag-enable controls, and resolves conditional squash against the selected flag. Unlike the fixed single-cycle stage, it adds a stall/flush handshake, multi-byte stack-write bursts for CALL/PSH with upstream back-pressure, and a saturating squash counter. It sits between stage 3 (CCG3) and the memory/register write-back stage.

## Interface
- OPC_W, 8, opcode width; decode uses bits [7:0].
- PUSH_BYTES, 1, bytes written per stack push/call (1..8).
- CNT_W, 16, squash-counter width.
- BIDX_W, derived localparam, max(1, clog2(PUSH_BYTES)).

- clk  in  1  global clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  downstream not ready; hold stage, suppress actions.
- flush  in  1  squash the instruction currently held in the stage.
- in_valid  in  1  stage-3 instruction valid.
- opcode  in  OPC_W  from opcode buffer.
- fl  in  1  selected condition flag.
- wr_in, xrn_in, xr0_in, ern_in, isp_in, efl_in  in  1 each  CCG3 control bits.
- busy  out  1  burst in progress; upstream must stall.
- out_valid  out  1  stage holds a live instruction.
- WR, LRN, LR0, LSP, DSP, LOP, ERN  out  1 each  action strobes.
- byte_idx  out  BIDX_W  current byte of a stack-write burst.
- sq_cnt  out  CNT_W  count of condition-failed instructions.

## Operation
- Capture: on a clock edge with !stall && !busy, load in_valid, opcode, fl and the six control bits into stage registers. With stall=1, hold all registers.
- Decode (combinational on the held opcode; first match wins):
  - LSP: 0x10.
  - dsp_d: 0x05, 0x06, 0x30–0x3F, 0x68–0x6F.
  - LOP: 0xF8–0xFF.
  - efl_d: 0x08–0x0F, 0x28–0x3F, 0x48–0x4F.
- Condition fail: cf = efl_d & ~fl_q.
- Resolved controls:
  - wr_r = wr_q & ~cf.
  - dsp_r = (isp_q & cf) | (dsp_d & ~cf).
- Action gating: every action output = resolved bit & out_valid & ~stall. Each action fires exactly once per instruction, on the cycle the stage advances.
- FSM states IDLE and BURST:
  - IDLE → BURST when out_valid & wr_r & dsp_r & (PUSH_BYTES > 1) & ~stall. busy rises in the same cycle.
  - In BURST, byte_idx advances on each non-stalled cycle. WR=DSP=1 on every beat.
  - LRN, LR0, ERN, LOP and LSP assert on beat 0 only.
  - BURST → IDLE after beat PUSH_BYTES-1 is issued. busy deasserts on that final beat, so capture occurs at the end of that cycle.
- Flush:
  - In IDLE, flush clears out_valid at the next edge and suppresses the current strobes that cycle.
  - In BURST, flush is ignored: the store is already committed.
  - flush with capture in the same cycle: flush wins and the new instruction is dropped. Upstream re-issues it.
- Squash counter: sq_cnt increments once per instruction that advances with out_valid & cf. It saturates at all-ones.

## Timing
- Latency: one cycle from capture edge to strobes. There is no combinational path from opcode/control inputs to outputs; only stall and flush gate outputs combinationally.
- Reset (async): all stage registers 0, out_valid=0, FSM=IDLE, busy=0, byte_idx=0, sq_cnt=0, all strobes 0.
- Reset mid-burst aborts immediately. The remaining beats are lost.
- stall during BURST holds byte_idx and suppresses WR/DSP for that cycle.
- PUSH_BYTES=1: the FSM never leaves IDLE, busy is constantly 0, and byte_idx=0.
- Burst beat order: byte_idx 0 is the LSB of the pushed value.

## Structure
- Package ccg_pkg:
  - ctrl_t struct {wr, xrn, xr0, ern, isp, efl}.
  - Opcode-range constants (OP_LSP, OP_CUD, OP_CUA, OP_CC_BASE, OP_PSH_BASE, OP_OUT_BASE, OP_JCD_BASE, OP_JCA_BASE, OP_RTC_BASE).
  - FSM state enum.
- Sub-module ccg4_decode: pure combinational opcode → {lsp, dsp_d, lop, efl_d}, reused by later stages.
- Top: stage registers, FSM, gating, counter.

## Test plan
- PSH 0x6A, wr_in=1, PUSH_BYTES=2 → busy=1 for one cycle; WR=DSP=1 on two beats with byte_idx 0 then 1; ERN only on beat 0.
- JCD 0x09, efl_in=1, fl=0, wr_in=1 → WR=0, DSP=0, sq_cnt 0→1; repeat with fl=1 → sq_cnt unchanged.
- RTC 0x4A, isp_in=1, fl=0 → DSP=1; same instruction with fl=1 → DSP=0.
- OUT 0xFC with stall high for 3 cycles, then low → LOP pulses exactly once, after the stall releases.
- Flush in IDLE with LSP 0x10 held → no LSP pulse, out_valid=0 next cycle. Flush during a burst → all beats still issued.
- Async rst asserted on burst beat 1 of 4 → busy, WR, byte_idx and sq_cnt are 0 immediately. With CNT_W=2, four failed-condition instructions leave sq_cnt=3.
